alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Registered decode-and-issue controller for the rv32imf execute stage. Decodes `alu_op`/`fun3`/`fun7`/`rs2`/`opcode` into an `alu_t` operation and a target unit class, then sequences the instruction through a per-class latency counter. It provides a valid/ready issue handshake, a done handshake and a flush. It sits between the ID/EX pipeline register and the ALU/multiplier/divider/FPU datapaths, and generates the execute-stage stall for multi-cycle operations.

## Interface
- `MUL_LAT`, 2: cycles for MUL/MULH/MULHSU/MULHU (≥1).
- `DIV_LAT`, 33: cycles for DIV/DIVU/REM/REMU (≥1).
- `FPU_LAT`, 3: cycles for non-divide float ops, including R4 fused ops (≥1).
- `FDIV_LAT`, 12: cycles for FDIV and FSQRT (≥1).
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `issue_valid`  in  1  an instruction is presented.
- `issue_ready`  out  1  controller can accept.
- `alu_op`  in  3  op class: LOAD_STORE, I_TYPE, B_TYPE, R_TYPE, R_float, R4_float, I_float, S_float.
- `fun3`, `fun7`, `rs2`, `opcode`  in  3/7/5/7  instruction fields.
- `kill`  in  1  flush; aborts any in-flight op.
- `alu_ctrl`  out  alu_t  registered operation of the accepted instruction.
- `unit_sel`  out  unit_t  registered target unit: UNIT_ALU, UNIT_MUL, UNIT_DIV, UNIT_FPU, UNIT_FDIV.
- `illegal`  out  1  registered; the accepted encoding was undecodable or disabled.
- `busy`  out  1  state is BUSY.
- `done_valid`  out  1  result is ready at the selected unit.
- `done_ready`  in  1  downstream consumes the result.

## Operation
- Decode follows standard RV32IMF encodings per op class:
  - R_TYPE: full `{fun7,fun3}` decode.
  - I_TYPE: `fun3`, with `fun7` selecting SRL or SRA.
  - B_TYPE: `fun3[2:1]` selects SUB, SLT or SLTU.
  - R_float: `fun7`, refined by `fun3` and by `rs2` for the FCVT variants.
  - R4_float: `opcode`.
  - LOAD_STORE, I_float, S_float: ADD.
- Unmatched R_TYPE/R_float encodings decode to ADD/FADD on UNIT_ALU/UNIT_FPU and set `illegal`.
- Unit class mapping:
  - MUL* → UNIT_MUL.
  - DIV*/REM* → UNIT_DIV.
  - FDIV, FSQRT → UNIT_FDIV.
  - All other float ops → UNIT_FPU.
  - Everything else → UNIT_ALU, with L=1.
- FSM states: IDLE, BUSY, DONE.
  - Accept occurs when `issue_valid && issue_ready && !kill`. On accept, register `alu_ctrl`, `unit_sel` and `illegal`.
  - If L=1, go to DONE. Otherwise go to BUSY with `cnt = L-1`.
  - BUSY: decrement `cnt` each cycle; when `cnt==1`, go to DONE.
  - DONE: `done_valid=1`, held until `done_ready`. On `done_ready`, go to IDLE, or re-accept in the same cycle (next state follows the new instruction).
- `issue_ready = (state==IDLE) || (state==DONE && done_ready)`. It is combinational from state and `done_ready`; it does not depend on `issue_valid`.
- `kill` in any state forces IDLE at the next edge, and no accept occurs that cycle. The registered `alu_ctrl`/`unit_sel` hold their last values.
- `cnt` width is `$clog2(max latency + 1)`. A latency of 1 never enters BUSY.

## Timing
- Reset values: state IDLE, `cnt` 0, `alu_ctrl` ADD, `unit_sel` UNIT_ALU, `illegal` 0, `busy` 0, `done_valid` 0. `issue_ready` is 1 during and after reset.
- For an accept at edge k, `done_valid` first rises after edge k+L-1. With L=1 this is the cycle right after accept.
- Back-to-back single-cycle ops sustain one issue per cycle while `done_ready` is held at 1.
- `busy` is high for L-1 cycles per multi-cycle op.
- `done_valid` stalled under `done_ready=0` holds with stable `alu_ctrl`/`unit_sel`.
- `kill` together with `done_ready`: kill wins and the result is dropped.
- Reset mid-BUSY returns to the reset values immediately (asynchronous).

## Configuration
- `ALU_ISSUE_FPU_EN` defined: float classes decode and issue as above.
- Not defined:
  - R_float and R4_float accept, set `illegal=1`, map to ADD/UNIT_ALU with L=1, and never reach BUSY.
  - I_float and S_float still issue as ADD/UNIT_ALU.
  - `FPU_LAT`/`FDIV_LAT` remain legal but unused.

## Structure
- `riscv_types` package holds `alu_t` and the alu_op class constants. Add `unit_t` and its values there.
- One combinational sub-module, `alu_op_decode`, produces `{alu_t, unit_t, illegal}` from the instruction fields. `alu_issue_ctrl` owns the FSM, the counter and the registers.

## Test plan
- Reset then ADD (R_TYPE, `{fun7,fun3}`=0) accepted with `done_ready`=1 → `done_valid` in the next cycle, `alu_ctrl`=ADD, `unit_sel`=UNIT_ALU, `busy` never high.
- DIV (`fun7`=0000001, `fun3`=100), DIV_LAT=33 → `busy` for 32 cycles, `issue_ready`=0 throughout, `done_valid` after edge k+32.
- FMUL with `done_ready`=0 for 5 cycles after done → `done_valid` stays high for those 5 cycles, then a new op is accepted in the same cycle `done_ready` rises.
- `kill` during cycle 10 of a DIV → next state IDLE, `done_valid` never asserts, `issue_ready`=1.
- R_TYPE `{fun7,fun3}`=0100000001 → `illegal`=1, `alu_ctrl`=ADD. Without `ALU_ISSUE_FPU_EN`, FADD → `illegal`=1 with L=1.
- Async `reset` pulse mid-BUSY (not on a clock edge) → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/riscv_types.sv
// riscv_types: operation, unit-class and decode-result types shared by the execute-stage issue logic
package riscv_types;
   typedef enum logic [5:0] {
      ADD = 6'd0, SLL, SLT, SLTU, XOR, SRL, OR, AND,
      SUB = 6'd8, SRA,
      MUL = 6'd16, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
      FADD = 6'd32, FSUB, FMUL, FDIV, FSQRT, FSGNJ, FSGNJN, FSGNJX, FMIN, FMAX,
      FCVT_W_S, FCVT_WU_S, FMV_X_W, FEQ, FLT, FLE, FCLASS, FCVT_S_W, FCVT_S_WU, FMV_W_X,
      FMADD, FMSUB, FNMSUB, FNMADD
   } alu_t;
   typedef enum logic [2:0] {UNIT_ALU, UNIT_MUL, UNIT_DIV, UNIT_FPU, UNIT_FDIV} unit_t;
   typedef struct packed {
      alu_t op;
      unit_t unit;
      logic illegal;
   } dec_t;
   localparam logic [2:0] LOAD_STORE = 3'd0;
   localparam logic [2:0] I_TYPE     = 3'd1;
   localparam logic [2:0] B_TYPE     = 3'd2;
   localparam logic [2:0] R_TYPE     = 3'd3;
   localparam logic [2:0] R_float    = 3'd4;
   localparam logic [2:0] R4_float   = 3'd5;
   localparam logic [2:0] I_float    = 3'd6;
   localparam logic [2:0] S_float    = 3'd7;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: issue/done handshake, instruction fields and registered decode results
interface alu_issue_ctrl_if;
   import riscv_types::*;
   logic issue_valid, issue_ready, kill, illegal, busy, done_valid, done_ready;
   logic [2:0] alu_op, fun3;
   logic [6:0] fun7, opcode;
   logic [4:0] rs2;
   alu_t alu_ctrl;
   unit_t unit_sel;
   modport master (
      output issue_valid, alu_op, fun3, fun7, rs2, opcode, kill, done_ready,
      input issue_ready, alu_ctrl, unit_sel, illegal, busy, done_valid
   );
   modport slave (
      input issue_valid, alu_op, fun3, fun7, rs2, opcode, kill, done_ready,
      output issue_ready, alu_ctrl, unit_sel, illegal, busy, done_valid
   );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: RV32IMF field decode to {op, unit, illegal}; float classes enabled by ALU_ISSUE_FPU_EN
module alu_op_decode import riscv_types::*; (
   input  logic [2:0] alu_op,
   input  logic [2:0] fun3,
   input  logic [6:0] fun7,
   input  logic [4:0] rs2,
   input  logic [6:0] opcode,
   output dec_t       dec
);
`ifdef ALU_ISSUE_FPU_EN
   localparam dec_t FP_BAD = '{FADD, UNIT_FPU, 1'b1};
   function automatic dec_t fp(alu_t op);
      return '{op, UNIT_FPU, 1'b0};
   endfunction
`else
   logic unused_fp;
   assign unused_fp = ^{rs2, opcode};
`endif
   // base and M-extension ops are laid out so fun3 indexes them directly
   always_comb begin
      dec = '{ADD, UNIT_ALU, 1'b0};
      case (alu_op)
         R_TYPE:
            if (fun7 == 7'b0000001) dec = '{alu_t'({3'b010, fun3}), fun3[2] ? UNIT_DIV : UNIT_MUL, 1'b0};
            else if (fun7 == 7'b0000000) dec.op = alu_t'({3'b000, fun3});
            else if (fun7 == 7'b0100000 && fun3 == 3'b000) dec.op = SUB;
            else if (fun7 == 7'b0100000 && fun3 == 3'b101) dec.op = SRA;
            else dec.illegal = 1'b1;
         I_TYPE: dec.op = fun3 == 3'b101 && fun7[5] ? SRA : alu_t'({3'b000, fun3});
         B_TYPE: dec.op = fun3[2:1] == 2'b11 ? SLTU : fun3[2:1] == 2'b10 ? SLT : SUB;
`ifdef ALU_ISSUE_FPU_EN
         R_float: begin
            dec = FP_BAD;
            case (fun7)
               7'b0000000: dec = fp(FADD);
               7'b0000100: dec = fp(FSUB);
               7'b0001000: dec = fp(FMUL);
               7'b0001100: dec = '{FDIV, UNIT_FDIV, 1'b0};
               7'b0101100: dec = '{FSQRT, UNIT_FDIV, 1'b0};
               7'b0010000: if (fun3 <= 3'd2) dec = fp(fun3 == 3'd0 ? FSGNJ : fun3 == 3'd1 ? FSGNJN : FSGNJX);
               7'b0010100: if (fun3 <= 3'd1) dec = fp(fun3[0] ? FMAX : FMIN);
               7'b1100000: if (rs2 <= 5'd1) dec = fp(rs2[0] ? FCVT_WU_S : FCVT_W_S);
               7'b1101000: if (rs2 <= 5'd1) dec = fp(rs2[0] ? FCVT_S_WU : FCVT_S_W);
               7'b1110000: if (fun3 <= 3'd1) dec = fp(fun3[0] ? FCLASS : FMV_X_W);
               7'b1010000: if (fun3 <= 3'd2) dec = fp(fun3 == 3'd2 ? FEQ : fun3 == 3'd1 ? FLT : FLE);
               7'b1111000: dec = fp(FMV_W_X);
               default: ;
            endcase
         end
         R4_float:
            case (opcode)
               7'b1000011: dec = fp(FMADD);
               7'b1000111: dec = fp(FMSUB);
               7'b1001011: dec = fp(FNMSUB);
               7'b1001111: dec = fp(FNMADD);
               default: dec = FP_BAD;
            endcase
`else
         R_float, R4_float: dec.illegal = 1'b1;
`endif
         default: ;
      endcase
   end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registered decode-and-issue FSM with per-unit latency counter and done handshake
module alu_issue_ctrl import riscv_types::*; #(
   parameter int MUL_LAT  = 2,
   parameter int DIV_LAT  = 33,
   parameter int FPU_LAT  = 3,
   parameter int FDIV_LAT = 12
) (
   input logic             clk,
   input logic             reset,
   alu_issue_ctrl_if.slave bus
);
   localparam int ML = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
   localparam int FL = FPU_LAT > FDIV_LAT ? FPU_LAT : FDIV_LAT;
   localparam int CW = $clog2((ML > FL ? ML : FL) + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt, lat;
   logic accept;
   dec_t dec;
   alu_op_decode u_dec (
      .alu_op(bus.alu_op), .fun3(bus.fun3), .fun7(bus.fun7),
      .rs2(bus.rs2), .opcode(bus.opcode), .dec(dec)
   );
   assign lat = dec.unit == UNIT_MUL  ? CW'(MUL_LAT)  :
                dec.unit == UNIT_DIV  ? CW'(DIV_LAT)  :
                dec.unit == UNIT_FPU  ? CW'(FPU_LAT)  :
                dec.unit == UNIT_FDIV ? CW'(FDIV_LAT) : CW'(1);
   assign bus.issue_ready = state == IDLE || (state == DONE && bus.done_ready);
   assign accept          = bus.issue_valid && bus.issue_ready && !bus.kill;
   assign bus.busy        = state == BUSY;
   assign bus.done_valid  = state == DONE;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         bus.alu_ctrl <= ADD;
         bus.unit_sel <= UNIT_ALU;
         bus.illegal  <= 1'b0;
      end else if (bus.kill) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (accept) begin
         state        <= lat == CW'(1) ? DONE : BUSY;
         cnt          <= lat - CW'(1);
         bus.alu_ctrl <= dec.op;
         bus.unit_sel <= dec.unit;
         bus.illegal  <= dec.illegal;
      end else if (state == BUSY) begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) state <= DONE;
      end else if (state == DONE && bus.done_ready) state <= IDLE;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven decode/latency vectors plus stall, kill and async-reset sequences
module tb_alu_issue_ctrl;
   import riscv_types::*;
   typedef struct {
      logic [2:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [4:0] r2;
      logic [6:0] opc;
      alu_t       e_op;
      unit_t      e_unit;
      logic       e_ill;
      int         e_lat;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1;
   int total = 0, bad = 0;
   vec_t v[$];
   alu_t exp_fmul;
   unit_t exp_fmul_unit;
   logic exp_fmul_ill;
   alu_issue_ctrl_if bus();
   alu_issue_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask
   task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] r2, input logic [6:0] opc);
      bus.alu_op = op;
      bus.fun3   = f3;
      bus.fun7   = f7;
      bus.rs2    = r2;
      bus.opcode = opc;
   endtask
   task automatic run_vec(input int i, input vec_t t);
      int lat, nbusy;
      logic rdy;
      chk($sformatf("v%0d_ready", i), bus.issue_ready, 1);
      drive(t.op, t.f3, t.f7, t.r2, t.opc);
      bus.issue_valid = 1'b1;
      bus.done_ready  = 1'b1;
      step();
      bus.issue_valid = 1'b0;
      chk($sformatf("v%0d_op", i), bus.alu_ctrl, t.e_op);
      chk($sformatf("v%0d_unit", i), bus.unit_sel, t.e_unit);
      chk($sformatf("v%0d_illegal", i), bus.illegal, t.e_ill);
      lat = 1;
      nbusy = 0;
      rdy = 1'b0;
      while (!bus.done_valid && lat < 64) begin
         nbusy += int'(bus.busy);
         rdy |= bus.issue_ready;
         step();
         lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, t.e_lat);
      chk($sformatf("v%0d_busy_cycles", i), nbusy, t.e_lat - 1);
      chk($sformatf("v%0d_ready_while_busy", i), rdy, 0);
      step();
      chk($sformatf("v%0d_consumed", i), bus.done_valid, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end
   initial begin
      int seen;
      bus.issue_valid = 1'b0;
      bus.kill = 1'b0;
      bus.done_ready = 1'b0;
      drive(R_TYPE, 3'b000, 7'b0, 5'd0, 7'd0);
      v.push_back('{R_TYPE, 3'b000, 7'b0000000, 5'd0, 7'd0, ADD, UNIT_ALU, 1'b0, 1});
      v.push_back('{R_TYPE, 3'b000, 7'b0100000, 5'd0, 7'd0, SUB, UNIT_ALU, 1'b0, 1});
      v.push_back('{R_TYPE, 3'b101, 7'b0100000, 5'd0, 7'd0, SRA, UNIT_ALU, 1'b0, 1});
      v.push_back('{R_TYPE, 3'b001, 7'b0100000, 5'd0, 7'd0, ADD, UNIT_ALU, 1'b1, 1});
      v.push_back('{R_TYPE, 3'b000, 7'b0000001, 5'd0, 7'd0, MUL, UNIT_MUL, 1'b0, 2});
      v.push_back('{R_TYPE, 3'b011, 7'b0000001, 5'd0, 7'd0, MULHU, UNIT_MUL, 1'b0, 2});
      v.push_back('{R_TYPE, 3'b100, 7'b0000001, 5'd0, 7'd0, DIV, UNIT_DIV, 1'b0, 33});
      v.push_back('{R_TYPE, 3'b111, 7'b0000001, 5'd0, 7'd0, REMU, UNIT_DIV, 1'b0, 33});
      v.push_back('{I_TYPE, 3'b101, 7'b0100000, 5'd0, 7'd0, SRA, UNIT_ALU, 1'b0, 1});
      v.push_back('{I_TYPE, 3'b101, 7'b0000000, 5'd0, 7'd0, SRL, UNIT_ALU, 1'b0, 1});
      v.push_back('{I_TYPE, 3'b111, 7'b0000000, 5'd0, 7'd0, AND, UNIT_ALU, 1'b0, 1});
      v.push_back('{B_TYPE, 3'b110, 7'b0000000, 5'd0, 7'd0, SLTU, UNIT_ALU, 1'b0, 1});
      v.push_back('{B_TYPE, 3'b100, 7'b0000000, 5'd0, 7'd0, SLT, UNIT_ALU, 1'b0, 1});
      v.push_back('{B_TYPE, 3'b001, 7'b0000000, 5'd0, 7'd0, SUB, UNIT_ALU, 1'b0, 1});
      v.push_back('{LOAD_STORE, 3'b010, 7'b0000000, 5'd0, 7'd0, ADD, UNIT_ALU, 1'b0, 1});
      v.push_back('{I_float, 3'b010, 7'b0000000, 5'd0, 7'd0, ADD, UNIT_ALU, 1'b0, 1});
      v.push_back('{S_float, 3'b010, 7'b0000000, 5'd0, 7'd0, ADD, UNIT_ALU, 1'b0, 1});
`ifdef ALU_ISSUE_FPU_EN
      v.push_back('{R_float, 3'b000, 7'b0000000, 5'd0, 7'd0, FADD, UNIT_FPU, 1'b0, 3});
      v.push_back('{R_float, 3'b000, 7'b0001100, 5'd0, 7'd0, FDIV, UNIT_FDIV, 1'b0, 12});
      v.push_back('{R_float, 3'b000, 7'b0101100, 5'd0, 7'd0, FSQRT, UNIT_FDIV, 1'b0, 12});
      v.push_back('{R_float, 3'b111, 7'b1100000, 5'd1, 7'd0, FCVT_WU_S, UNIT_FPU, 1'b0, 3});
      v.push_back('{R_float, 3'b000, 7'b1100000, 5'd2, 7'd0, FADD, UNIT_FPU, 1'b1, 3});
      v.push_back('{R_float, 3'b010, 7'b1010000, 5'd0, 7'd0, FEQ, UNIT_FPU, 1'b0, 3});
      v.push_back('{R4_float, 3'b000, 7'b0000000, 5'd0, 7'b1001111, FNMADD, UNIT_FPU, 1'b0, 3});
      exp_fmul = FMUL;
      exp_fmul_unit = UNIT_FPU;
      exp_fmul_ill = 1'b0;
`else
      v.push_back('{R_float, 3'b000, 7'b0000000, 5'd0, 7'd0, ADD, UNIT_ALU, 1'b1, 1});
      v.push_back('{R_float, 3'b000, 7'b0001100, 5'd0, 7'd0, ADD, UNIT_ALU, 1'b1, 1});
      v.push_back('{R4_float, 3'b000, 7'b0000000, 5'd0, 7'b1000011, ADD, UNIT_ALU, 1'b1, 1});
      exp_fmul = ADD;
      exp_fmul_unit = UNIT_ALU;
      exp_fmul_ill = 1'b1;
`endif
      step();
      step();
      chk("rst_ready", bus.issue_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done_valid, 0);
      chk("rst_op", bus.alu_ctrl, ADD);
      chk("rst_unit", bus.unit_sel, UNIT_ALU);
      chk("rst_illegal", bus.illegal, 0);
      reset = 1'b0;
      step();
      foreach (v[i]) run_vec(i, v[i]);
      // back-to-back single-cycle issue
      bus.done_ready = 1'b1;
      bus.issue_valid = 1'b1;
      drive(R_TYPE, 3'b000, 7'b0100000, 5'd0, 7'd0);
      step();
      chk("b2b_sub", bus.alu_ctrl, SUB);
      chk("b2b_done0", bus.done_valid, 1);
      drive(R_TYPE, 3'b100, 7'b0000000, 5'd0, 7'd0);
      step();
      chk("b2b_xor", bus.alu_ctrl, XOR);
      chk("b2b_done1", bus.done_valid, 1);
      drive(R_TYPE, 3'b101, 7'b0100000, 5'd0, 7'd0);
      step();
      chk("b2b_sra", bus.alu_ctrl, SRA);
      chk("b2b_done2", bus.done_valid, 1);
      bus.issue_valid = 1'b0;
      step();
      chk("b2b_idle", bus.done_valid, 0);
      // result stalled by done_ready=0, then re-accept on release
      bus.done_ready = 1'b0;
      bus.issue_valid = 1'b1;
      drive(R_float, 3'b000, 7'b0001000, 5'd0, 7'd0);
      step();
      bus.issue_valid = 1'b0;
      seen = 0;
      while (!bus.done_valid && seen < 64) begin
         step();
         seen++;
      end
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d_done", c), bus.done_valid, 1);
         chk($sformatf("stall%0d_op", c), bus.alu_ctrl, exp_fmul);
         chk($sformatf("stall%0d_ready", c), bus.issue_ready, 0);
         step();
      end
      chk("stall_unit", bus.unit_sel, exp_fmul_unit);
      chk("stall_illegal", bus.illegal, exp_fmul_ill);
      bus.done_ready = 1'b1;
      bus.issue_valid = 1'b1;
      drive(R_TYPE, 3'b100, 7'b0000000, 5'd0, 7'd0);
      #1;
      chk("release_ready", bus.issue_ready, 1);
      step();
      bus.issue_valid = 1'b0;
      chk("release_op", bus.alu_ctrl, XOR);
      chk("release_unit", bus.unit_sel, UNIT_ALU);
      chk("release_done", bus.done_valid, 1);
      step();
      // kill in cycle 10 of a divide
      bus.issue_valid = 1'b1;
      drive(R_TYPE, 3'b100, 7'b0000001, 5'd0, 7'd0);
      step();
      bus.issue_valid = 1'b0;
      repeat (8) step();
      chk("kill_pre_busy", bus.busy, 1);
      bus.issue_valid = 1'b1;
      bus.kill = 1'b1;
      drive(R_TYPE, 3'b000, 7'b0100000, 5'd0, 7'd0);
      step();
      bus.kill = 1'b0;
      bus.issue_valid = 1'b0;
      chk("kill_busy", bus.busy, 0);
      chk("kill_done", bus.done_valid, 0);
      chk("kill_ready", bus.issue_ready, 1);
      chk("kill_op_hold", bus.alu_ctrl, DIV);
      chk("kill_unit_hold", bus.unit_sel, UNIT_DIV);
      seen = 0;
      repeat (40) begin
         step();
         seen |= int'(bus.done_valid);
      end
      chk("kill_no_done", seen, 0);
      // kill wins over done_ready in DONE
      bus.done_ready = 1'b0;
      bus.issue_valid = 1'b1;
      drive(R_TYPE, 3'b111, 7'b0000000, 5'd0, 7'd0);
      step();
      bus.issue_valid = 1'b0;
      chk("kdr_done_pre", bus.done_valid, 1);
      bus.kill = 1'b1;
      bus.done_ready = 1'b1;
      bus.issue_valid = 1'b1;
      drive(R_TYPE, 3'b000, 7'b0100000, 5'd0, 7'd0);
      step();
      bus.kill = 1'b0;
      bus.issue_valid = 1'b0;
      chk("kdr_done", bus.done_valid, 0);
      chk("kdr_op_hold", bus.alu_ctrl, AND);
      // asynchronous reset in the middle of a divide
      bus.issue_valid = 1'b1;
      drive(R_TYPE, 3'b100, 7'b0000001, 5'd0, 7'd0);
      step();
      bus.issue_valid = 1'b0;
      repeat (4) step();
      chk("arst_pre_busy", bus.busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_done", bus.done_valid, 0);
      chk("arst_ready", bus.issue_ready, 1);
      chk("arst_op", bus.alu_ctrl, ADD);
      chk("arst_unit", bus.unit_sel, UNIT_ALU);
      chk("arst_illegal", bus.illegal, 0);
      #1;
      reset = 1'b0;
      step();
      chk("arst_after_busy", bus.busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
